// File: rtl/upower_fetch_decode.sv
// Fetch and field-decode stage for the uPower control unit: one outstanding imem request,
// a single decode register, and branch redirect with flush of held and in-flight words.
module upower_fetch_decode #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [PC_W-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [5:0]      opcode,
  output logic [9:0]      xox,
  output logic [8:0]      xoxo,
  output logic [1:0]      xods,
  output logic [4:0]      rt,
  output logic [4:0]      ra,
  output logic [4:0]      rb,
  output logic [15:0]     imm16,
  output logic [23:0]     li,
  output logic [13:0]     bd,
  output logic            aa,
  output logic            lk
);

  typedef enum logic [1:0] {StFetch, StWait, StDiscard} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] id_pc_q, id_pc_d;
  logic [31:0]     id_instr_q, id_instr_d;
  logic            id_valid_q, id_valid_d;
  logic            slot_free;
  logic            capture;
  logic            unused_target_bits;

  assign unused_target_bits = ^branch_target[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    capture    = 1'b0;
    imem_req   = 1'b0;
    // Only issue when the slot is guaranteed empty by the time the response lands.
    slot_free  = !id_valid_q || id_ready;

    unique case (state_q)
      StFetch: begin
        if (slot_free) begin
          imem_req = rst_n;
          state_d  = branch_taken ? StDiscard : StWait;
        end
      end
      StWait: begin
        if (imem_valid) begin
          capture = !branch_taken;
          state_d = StFetch;
        end else if (branch_taken) begin
          state_d = StDiscard;
        end
      end
      StDiscard: begin
        if (imem_valid) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase

    if (id_valid_q && id_ready) id_valid_d = 1'b0;

    if (capture) begin
      id_valid_d = 1'b1;
      id_instr_d = imem_rdata;
      id_pc_d    = pc_q;
      pc_d       = pc_q + PC_W'(4);
    end

    // Redirect overrides capture and consumption alike.
    if (branch_taken) begin
      id_valid_d = 1'b0;
      pc_d       = {branch_target[PC_W-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_instr_q <= '0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign id_instr  = id_instr_q;

  assign opcode = id_instr_q[31:26];
  assign rt     = id_instr_q[25:21];
  assign ra     = id_instr_q[20:16];
  assign rb     = id_instr_q[15:11];
  assign xox    = id_instr_q[10:1];
  assign xoxo   = id_instr_q[9:1];
  assign xods   = id_instr_q[1:0];
  assign imm16  = id_instr_q[15:0];
  assign li     = id_instr_q[25:2];
  assign bd     = id_instr_q[15:2];
  assign aa     = id_instr_q[1];
  assign lk     = id_instr_q[0];

endmodule

// File: tb/tb_upower_fetch_decode.sv
// Bench for upower_fetch_decode: decode table, directed stall/redirect/reset sequences,
// then random traffic against an address-stream scoreboard.
module tb_upower_fetch_decode;

  localparam logic [31:0] RPC = 32'h100;
  localparam int NV = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        id_ready = 1'b1;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [5:0]  opcode;
  logic [9:0]  xox;
  logic [8:0]  xoxo;
  logic [1:0]  xods;
  logic [4:0]  rt, ra, rb;
  logic [15:0] imm16;
  logic [23:0] li;
  logic [13:0] bd;
  logic        aa, lk;

  upower_fetch_decode #(.PC_W(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .branch_taken(branch_taken),
    .branch_target(branch_target), .id_ready(id_ready), .id_valid(id_valid), .id_pc(id_pc),
    .id_instr(id_instr), .opcode(opcode), .xox(xox), .xoxo(xoxo), .xods(xods), .rt(rt),
    .ra(ra), .rb(rb), .imm16(imm16), .li(li), .bd(bd), .aa(aa), .lk(lk)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rt, ra, rb;
    logic [9:0]  xox;
    logic [8:0]  xoxo;
    logic [1:0]  xods;
    logic [15:0] imm16;
    logic [23:0] li;
    logic [13:0] bd;
    logic        aa, lk;
  } vec_t;

  vec_t tab [NV];
  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction memory contents: the decode table at RESET_PC, a hash elsewhere.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a >= RPC && a < RPC + 4 * NV) return tab[(a - RPC) >> 2].instr;
    return a * 32'h9E3779B1 + 32'h7F4A7C15;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fields(input logic [31:0] w);
    check("opcode", opcode, w >> 26);
    check("rt", rt, (w >> 21) & 31);
    check("ra", ra, (w >> 16) & 31);
    check("rb", rb, (w >> 11) & 31);
    check("xox", xox, (w >> 1) & 1023);
    check("xoxo", xoxo, (w >> 1) & 511);
    check("xods", xods, w & 3);
    check("imm16", imm16, w & 32'hFFFF);
    check("li", li, (w >> 2) & 32'hFF_FFFF);
    check("bd", bd, (w >> 2) & 32'h3FFF);
    check("aa", aa, (w >> 1) & 1);
    check("lk", lk, w & 1);
  endtask

  task automatic check_tab(input int k);
    check("tab_valid", id_valid, 1);
    check("tab_pc", id_pc, RPC + 4 * k);
    check("tab_instr", id_instr, tab[k].instr);
    check("tab_opcode", opcode, tab[k].opcode);
    check("tab_rt", rt, tab[k].rt);
    check("tab_ra", ra, tab[k].ra);
    check("tab_rb", rb, tab[k].rb);
    check("tab_xox", xox, tab[k].xox);
    check("tab_xoxo", xoxo, tab[k].xoxo);
    check("tab_xods", xods, tab[k].xods);
    check("tab_imm16", imm16, tab[k].imm16);
    check("tab_li", li, tab[k].li);
    check("tab_bd", bd, tab[k].bd);
    check("tab_aa", aa, tab[k].aa);
    check("tab_lk", lk, tab[k].lk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_valid = 1'b0;
    branch_taken = 1'b0;
    id_ready = 1'b1;
    #1;
    check("rst_req", imem_req, 0);
    check("rst_valid", id_valid, 0);
    check("rst_pc", id_pc, 0);
    check("rst_instr", id_instr, 0);
    check("rst_opcode", opcode, 0);
    check("rst_li", li, 0);
    cyc();
    cyc();
    check("rst_req_hold", imem_req, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    logic        pending, br, prev_br;
    int          cnt, idle;
    logic [31:0] paddr, exp_addr, exp_idpc, tgt;

    tab[0] = '{32'h7C642A14, 6'd31, 5'd3, 5'd4, 5'd5, 10'd266, 9'd266, 2'd0, 16'h2A14,
               24'h190A85, 14'hA85, 1'b0, 1'b0};
    tab[1] = '{32'h38610005, 6'd14, 5'd3, 5'd1, 5'd0, 10'd2, 9'd2, 2'd1, 16'h0005,
               24'h184001, 14'h1, 1'b0, 1'b1};
    tab[2] = '{32'hE8610008, 6'd58, 5'd3, 5'd1, 5'd0, 10'd4, 9'd4, 2'd0, 16'h0008,
               24'h184002, 14'h2, 1'b0, 1'b0};
    tab[3] = '{32'hFFFFFFFF, 6'd63, 5'd31, 5'd31, 5'd31, 10'd1023, 9'd511, 2'd3, 16'hFFFF,
               24'hFFFFFF, 14'h3FFF, 1'b1, 1'b1};
    tab[4] = '{32'h48000001, 6'd18, 5'd0, 5'd0, 5'd0, 10'd0, 9'd0, 2'd1, 16'h0001,
               24'h0, 14'h0, 1'b0, 1'b1};

    // Table: 1-cycle memory, id_ready=1, requests on alternate cycles.
    do_reset();
    for (int k = 0; k < NV; k++) begin
      imem_valid = 1'b0;
      #1;
      check("seq_req", imem_req, 1);
      check("seq_addr", imem_addr, RPC + 4 * k);
      if (k > 0) check_tab(k - 1);
      else check("seq_first_valid", id_valid, 0);
      cyc();
      imem_valid = 1'b1;
      imem_rdata = tab[k].instr;
      #1;
      check("seq_wait_noreq", imem_req, 0);
      cyc();
    end
    imem_valid = 1'b0;
    #1;
    check_tab(NV - 1);

    // Stall with a held instruction, then release.
    do_reset();
    #1;
    check("st_req", imem_req, 1);
    cyc();
    imem_valid = 1'b1;
    imem_rdata = memf(RPC);
    id_ready = 1'b0;
    cyc();
    imem_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("st_noreq", imem_req, 0);
      check("st_valid", id_valid, 1);
      check("st_pc", id_pc, RPC);
      check("st_instr", id_instr, memf(RPC));
      cyc();
    end
    id_ready = 1'b1;
    #1;
    check("st_release_req", imem_req, 1);
    check("st_release_addr", imem_addr, RPC + 4);

    // Redirect in WAIT to an unaligned target; response arrives 3 cycles later.
    cyc();
    branch_taken = 1'b1;
    branch_target = 32'h203;
    #1;
    check("br_noreq", imem_req, 0);
    cyc();
    branch_taken = 1'b0;
    branch_target = '0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("br_disc_noreq", imem_req, 0);
      check("br_disc_valid", id_valid, 0);
      cyc();
    end
    imem_valid = 1'b1;
    imem_rdata = memf(RPC + 4);
    #1;
    check("br_resp_noreq", imem_req, 0);
    cyc();
    imem_valid = 1'b0;
    #1;
    check("br_dropped", id_valid, 0);
    check("br_req", imem_req, 1);
    check("br_addr", imem_addr, 32'h200);
    cyc();
    imem_valid = 1'b1;
    imem_rdata = memf(32'h200);
    cyc();
    imem_valid = 1'b0;
    #1;
    check("br_tgt_valid", id_valid, 1);
    check("br_tgt_pc", id_pc, 32'h200);
    check("br_tgt_instr", id_instr, memf(32'h200));
    check("br_next_addr", imem_addr, 32'h204);

    // Reset in the middle of WAIT, stale response right after release.
    cyc();
    do_reset();
    imem_valid = 1'b1;
    imem_rdata = memf(32'h204);
    #1;
    check("rw_req", imem_req, 1);
    check("rw_addr", imem_addr, RPC);
    check("rw_valid", id_valid, 0);
    cyc();
    imem_valid = 1'b0;
    #1;
    check("rw_stale_valid", id_valid, 0);
    check("rw_stale_instr", id_instr, 0);
    cyc();
    imem_valid = 1'b1;
    imem_rdata = memf(RPC);
    #1;
    check("rw_still_zero", id_instr, 0);
    cyc();
    imem_valid = 1'b0;
    #1;
    check("rw_valid_after", id_valid, 1);
    check("rw_pc_after", id_pc, RPC);
    check("rw_instr_after", id_instr, memf(RPC));

    // Random traffic: variable memory latency, back-pressure and redirects.
    do_reset();
    pending = 1'b0;
    cnt = 0;
    paddr = '0;
    exp_addr = RPC;
    exp_idpc = RPC;
    prev_br = 1'b0;
    idle = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) cyc();
      if (pending) cnt--;
      imem_valid = pending && cnt == 0;
      imem_rdata = imem_valid ? memf(paddr) : $urandom;
      id_ready = ($urandom_range(0, 3) != 0);
      br = ($urandom_range(0, 31) == 0);
      tgt = $urandom & 32'hFFF;
      branch_taken = br;
      branch_target = tgt;
      #1;
      if (prev_br) check("rnd_flush", id_valid, 0);
      if (imem_req) begin
        check("rnd_one_outstanding", pending, 0);
        check("rnd_slot_free", !id_valid || id_ready, 1);
        check("rnd_fetch_addr", imem_addr, exp_addr);
      end
      if (id_valid) begin
        check("rnd_id_pc", id_pc, exp_idpc);
        check("rnd_id_instr", id_instr, memf(exp_idpc));
        check_fields(memf(exp_idpc));
      end
      if (id_valid && id_ready) idle = 0;
      else idle++;
      if (idle > 100) begin
        total++;
        bad++;
        $display("FAIL rnd_progress: got %0d idle cycles want <=100", idle);
        break;
      end
      if (imem_valid) pending = 1'b0;
      if (imem_req) begin
        pending = 1'b1;
        cnt = $urandom_range(1, 3);
        paddr = imem_addr;
      end
      if (br) begin
        exp_addr = tgt & ~32'h3;
        exp_idpc = tgt & ~32'h3;
      end else begin
        if (imem_req) exp_addr += 4;
        if (id_valid && id_ready) exp_idpc += 4;
      end
      prev_br = br;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/upower_fetch_decode.md
Name: upower_fetch_decode

Overview:
Instruction fetch and field-decode stage feeding the uPower control unit.
- Keeps the PC and issues one instruction-memory request at a time.
- Captures the returned 32-bit word into a decode output register.
- Splits the word into opcode/xox/xoxo/xods and the register/immediate fields consumed by the control unit, register file and ALU.
- Handles taken-branch redirect with flush of held and in-flight instructions.

Parameters:
PC_W, 32, PC and instruction-address width in bits.
RESET_PC, 0, PC value loaded on reset; low 2 bits must be zero.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
imem_req  out  1  single-cycle fetch request pulse.
imem_addr  out  PC_W  fetch address, valid while imem_req=1.
imem_valid  in  1  response strobe, at least 1 cycle after imem_req.
imem_rdata  in  32  instruction word, valid with imem_valid.
branch_taken  in  1  redirect strobe from branch resolution.
branch_target  in  PC_W  redirect address; bits [1:0] ignored and forced 0.
id_ready  in  1  downstream consumes id_* this cycle when id_valid=1.
id_valid  out  1  decode register holds a valid instruction.
id_pc  out  PC_W  address of the held instruction.
id_instr  out  32  raw held instruction.
opcode  out  6  instr[31:26].
xox  out  10  X-form extended opcode, instr[10:1].
xoxo  out  9  XO-form extended opcode, instr[9:1].
xods  out  2  DS-form extended opcode, instr[1:0].
rt  out  5  RT/RS/BO, instr[25:21].
ra  out  5  RA/BI, instr[20:16].
rb  out  5  RB, instr[15:11].
imm16  out  16  D-form SI/UI/D, instr[15:0].
li  out  24  I-form LI, instr[25:2].
bd  out  14  B-form BD, instr[15:2].
aa  out  1  instr[1].
lk  out  1  instr[0].

Behaviour:
- Field outputs are purely combinational slices of id_instr; no sign extension in this block.
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=FETCH, id_valid=0, id_pc=0, id_instr=0, imem_req=0.
  - All field outputs are therefore 0.
- States:
  - FETCH: imem_req=1 and imem_addr=pc when the slot is free, i.e. (!id_valid || id_ready). Then go to WAIT. Otherwise stay in FETCH with imem_req=0.
  - WAIT: on imem_valid, id_instr<=imem_rdata, id_pc<=pc, id_valid<=1, pc<=pc+4 (mod 2^PC_W wrap), go to FETCH.
  - DISCARD: a fetch is outstanding but has been killed. On imem_valid, drop the data and go to FETCH; pc is unchanged (already the target).
- At most one outstanding request.
  - A request is only issued when the slot will be empty, so a response never finds id_valid=1 unconsumed.
  - A response arriving in the same cycle as id_ready reloads the slot.
- Consumption: id_valid && id_ready && no new capture -> id_valid<=0.
- Latency: first imem_req in the first cycle after rst_n rises. id_valid rises the cycle after imem_valid. Peak throughput is 1 instruction per 2 cycles with 1-cycle memory.
- Redirect (branch_taken=1), highest priority over everything else:
  - pc<=branch_target with [1:0]=00, and id_valid<=0 regardless of id_ready.
  - In FETCH with a request issued this cycle -> DISCARD. Without a request -> stay in FETCH.
  - In WAIT without imem_valid -> DISCARD. In WAIT with imem_valid the same cycle -> data dropped, FETCH.
  - In DISCARD without imem_valid -> stay in DISCARD. With imem_valid -> FETCH.
- Back-to-back redirects: the last one wins the pc.
- Reset mid-operation: immediate return to reset values. Any late imem_valid arriving in FETCH after reset is ignored.
- imem_valid in FETCH state is ignored.
- id_* are stable while id_valid=1 and id_ready=0.

Test Plan:
- Reset with RESET_PC=0x100, 1-cycle memory, id_ready=1 -> imem_req at 0x100, then 0x104, 0x108 on alternate cycles; id_pc follows 0x100, 0x104, …; no gaps beyond 1 cycle.
- Return 0x7C642A14 (add r3,r4,r5) -> opcode=31, rt=3, ra=4, rb=5, xox=266, xoxo=266, aa=0, lk=0.
- Return 0x38610005 (addi) then 0xE8610008 (ld) -> opcode 14, rt=3, ra=1, imm16=0x0005; then opcode 58, imm16=0x0008, xods=0.
- Hold id_ready=0 for 5 cycles with id_valid=1 -> no imem_req, id_* constant. Release -> next request issued the same cycle.
- branch_taken with target 0x203 while in WAIT, response 3 cycles later -> response dropped, id_valid=0, next imem_addr=0x200.
- Assert rst_n=0 mid-WAIT, then deliver imem_valid after release -> outputs stay zero until a fresh fetch at RESET_PC completes.
